// File: rtl/dom_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dom_pkg: shared types and constants for the DOM multiplier slice  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package dom_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        CLEAR = 3'd4
    } sched_state_t;

    localparam logic [15:0] c_lfsr_seed_dflt = 16'hACE1;

    // Galois feedback masks, bit k set for tap x^(k+1)
    localparam logic [7:0]  c_lfsr_poly_w8  = 8'hB8;
    localparam logic [15:0] c_lfsr_poly_w16 = 16'hB400;
    localparam logic [23:0] c_lfsr_poly_w24 = 24'hE1_0000;
    localparam logic [31:0] c_lfsr_poly_w32 = 32'hA300_0000;

    function automatic logic [31:0] lfsr_poly(input int w);
        case (w)
            8:       return 32'(c_lfsr_poly_w8);
            24:      return 32'(c_lfsr_poly_w24);
            32:      return c_lfsr_poly_w32;
            default: return 32'(c_lfsr_poly_w16);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dom_lfsr.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dom_lfsr: Galois LFSR supplying fresh masks, with seed loading    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module dom_lfsr
    import dom_pkg::*;
#(
    parameter int             W    = 16,
    parameter logic [W-1:0]   SEED = W'(c_lfsr_seed_dflt)
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         step,
    input  logic         load,
    input  logic [W-1:0] seed,
    output logic [W-1:0] state
);
    localparam logic [W-1:0] c_mask = W'(lfsr_poly(W));

    logic [W-1:0] r_state;

    // An all-zero seed would lock the register, so it falls back to SEED
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= SEED;
        end else if (load) begin
            r_state <= (seed == '0) ? SEED : seed;
        end else if (step) begin
            r_state <= (r_state >> 1) ^ (r_state[0] ? c_mask : '0);
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/dom_mult.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dom_mult: first-order DOM-indep AND gate, one register stage      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module dom_mult (
    input  logic clk,
    input  logic rstn,
    input  logic Ax,
    input  logic Ay,
    input  logic Bx,
    input  logic By,
    input  logic Z0,
    output logic Aq,
    output logic Bq
);
    logic r_xx, r_xy, r_yx, r_yy;

    // Cross-domain terms are blinded by Z0 before the register stage
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_xx <= 1'b0;
            r_xy <= 1'b0;
            r_yx <= 1'b0;
            r_yy <= 1'b0;
        end else begin
            r_xx <= Ax & Bx;
            r_xy <= (Ax & By) ^ Z0;
            r_yx <= (Ay & Bx) ^ Z0;
            r_yy <= Ay & By;
        end
    end

    assign Aq = r_xx ^ r_xy;
    assign Bq = r_yy ^ r_yx;

endmodule
`default_nettype wire

// File: rtl/dom_mult_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dom_mult_sched: round-robin scheduler sharing one dom_mult        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module dom_mult_sched
    import dom_pkg::*;
#(
    parameter int                NREQ      = 4,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(c_lfsr_seed_dflt)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_ax,
    input  logic [NREQ-1:0]         req_ay,
    input  logic [NREQ-1:0]         req_bx,
    input  logic [NREQ-1:0]         req_by,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic                    rsp_qx,
    output logic                    rsp_qy,
    input  logic                    rsp_ready,
    input  logic                    seed_load,
    input  logic [LFSR_W-1:0]       seed,
    output logic                    busy
);
    localparam int IDW = $clog2(NREQ);

    sched_state_t    r_state, w_state_nxt;
    logic [IDW-1:0]  r_last, r_rsp_id, w_pick;
    logic            r_ax, r_ay, r_bx, r_by, r_rsp_qx, r_rsp_qy;
    logic            w_any, w_accept, w_drive, w_step, w_load;
    logic            w_ax, w_ay, w_bx, w_by, w_z0, w_aq, w_bq;
    logic [LFSR_W-1:0] w_lfsr;

    // Scan downward so the nearest index after the last grant wins
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                               input logic [IDW-1:0]  last);
        logic [IDW-1:0] pick;
        int             idx;
        pick = last;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NREQ;
            if (v[IDW'(idx)]) pick = IDW'(idx);
        end
        return pick;
    endfunction

    assign w_any    = |req_valid;
    assign w_pick   = rr_pick(req_valid, r_last);
    assign w_accept = (r_state == IDLE) && w_any;
    assign w_drive  = (r_state == ISSUE) || (r_state == WAIT);
    assign w_step   = (r_state == CLEAR);
    assign w_load   = (r_state == IDLE) && seed_load;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = WAIT;
            WAIT:    w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = CLEAR;
            CLEAR:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // r_last starts at NREQ-1 so requester 0 is first in line out of reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last   <= IDW'(NREQ - 1);
            r_ax     <= 1'b0;
            r_ay     <= 1'b0;
            r_bx     <= 1'b0;
            r_by     <= 1'b0;
            r_rsp_id <= '0;
            r_rsp_qx <= 1'b0;
            r_rsp_qy <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last <= w_pick;
                r_ax   <= req_ax[w_pick];
                r_ay   <= req_ay[w_pick];
                r_bx   <= req_bx[w_pick];
                r_by   <= req_by[w_pick];
            end
            if (r_state == WAIT) begin
                r_rsp_id <= r_last;
                r_rsp_qx <= w_aq;
                r_rsp_qy <= w_bq;
            end
        end
    end

    // Multiplier inputs are precharged to zero outside the compute window
    assign w_ax = w_drive & r_ax;
    assign w_ay = w_drive & r_ay;
    assign w_bx = w_drive & r_bx;
    assign w_by = w_drive & r_by;
    assign w_z0 = w_drive & w_lfsr[0];

    dom_mult u_mult (clk, rstn, w_ax, w_ay, w_bx, w_by, w_z0, w_aq, w_bq);

    dom_lfsr #(
        .W    (LFSR_W),
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rstn  (rstn),
        .step  (w_step),
        .load  (w_load),
        .seed  (seed),
        .state (w_lfsr)
    );

    assign req_ready = w_accept ? (NREQ'(1) << w_pick) : '0;
    assign rsp_valid = (r_state == RESP);
    assign rsp_id    = r_rsp_id;
    assign rsp_qx    = r_rsp_qx;
    assign rsp_qy    = r_rsp_qy;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire
